// File: rtl/redmule_zbuf_seq.sv
// Z-tile buffer: captures Depth result columns, then drains rows_q rows; full_o/z_valid_o/empty_o follow the causing edge by one cycle.
// Backpressure: z_o/z_strb_o hold while z_valid_o && !z_ready_i; fills outside EMPTY/FILLING are dropped.
module redmule_zbuf_seq #(
    parameter int unsigned Height      = 4,
    parameter int unsigned Width       = 8,
    parameter int unsigned NumPipeRegs = 3,
    parameter int unsigned DataW       = 16,
    localparam int unsigned Depth      = (NumPipeRegs + 1) * Height,
    localparam int unsigned RowW       = $clog2(Width + 1),
    localparam int unsigned ColW       = $clog2(Depth + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       clk_en_i,
    input  logic                       fill_i,
    input  logic [Width*DataW-1:0]     z_i,
    input  logic [RowW-1:0]            z_rows_i,
    input  logic [ColW-1:0]            z_cols_i,
    input  logic                       drain_en_i,
    output logic [Depth*DataW-1:0]     z_o,
    output logic [Depth*DataW/8-1:0]   z_strb_o,
    output logic                       z_valid_o,
    input  logic                       z_ready_i,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned FcW   = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned DcW   = (Width > 1) ? $clog2(Width) : 1;
    localparam int unsigned StrbW = Depth * DataW / 8;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FILLING,
        S_FULL,
        S_DRAINING
    } state_t;

    state_t           state_q, state_d;
    logic [FcW-1:0]   fill_cnt;
    logic [DcW-1:0]   drain_cnt;
    logic [RowW-1:0]  rows_q;
    logic [ColW-1:0]  cols_q;
    logic             empty_d;
    logic [DataW-1:0] mem_q [Width][Depth];

    logic fill_acc, last_col, handshake, last_row;
    logic [RowW-1:0] rows_new;
    logic [ColW-1:0] cols_new;

    assign fill_acc  = fill_i && clk_en_i && !clear_i &&
                       (state_q == S_EMPTY || state_q == S_FILLING);
    assign last_col  = (fill_cnt == FcW'(Depth - 1));
    assign handshake = (state_q == S_DRAINING) && z_ready_i;
    assign last_row  = (RowW'(drain_cnt) == rows_q - RowW'(1));

    // Zero or oversized leftovers mean a full-size tile
    assign rows_new = (z_rows_i == '0 || z_rows_i > RowW'(Width)) ? RowW'(Width) : z_rows_i;
    assign cols_new = (z_cols_i == '0 || z_cols_i > ColW'(Depth)) ? ColW'(Depth) : z_cols_i;

    assign full_o    = (state_q == S_FULL);
    assign z_valid_o = (state_q == S_DRAINING);

    always_comb begin
        state_d = state_q;
        empty_d = 1'b0;
        case (state_q)
            S_EMPTY:    if (fill_acc) state_d = S_FILLING;
            S_FILLING:  if (fill_acc && last_col) state_d = S_FULL;
            S_FULL:     if (drain_en_i) state_d = S_DRAINING;
            S_DRAINING: begin
                if (handshake && last_row) begin
                    state_d = S_EMPTY;
                    empty_d = 1'b1;
                end
            end
            default:    state_d = S_EMPTY;
        endcase
        if (clear_i) begin
            state_d = S_EMPTY;
            empty_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_EMPTY;
            empty_o <= 1'b0;
        end else begin
            state_q <= state_d;
            empty_o <= empty_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fill_cnt  <= '0;
            drain_cnt <= '0;
            rows_q    <= '0;
            cols_q    <= '0;
        end else if (clear_i) begin
            fill_cnt  <= '0;
            drain_cnt <= '0;
            rows_q    <= '0;
            cols_q    <= '0;
        end else begin
            if (fill_acc) begin
                fill_cnt <= last_col ? '0 : fill_cnt + 1'b1;
                if (state_q == S_EMPTY) begin
                    rows_q <= rows_new;
                    cols_q <= cols_new;
                end
            end
            if (state_q == S_FULL && drain_en_i) begin
                drain_cnt <= '0;
            end else if (handshake) begin
                drain_cnt <= last_row ? '0 : drain_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < Width; r++) begin
                for (int c = 0; c < Depth; c++) begin
                    mem_q[r][c] <= '0;
                end
            end
        end else if (fill_acc) begin
            for (int r = 0; r < Width; r++) begin
                mem_q[r][fill_cnt] <= z_i[r*DataW +: DataW];
            end
        end
    end

    always_comb begin
        z_o = '0;
        if (z_valid_o) begin
            for (int c = 0; c < Depth; c++) begin
                z_o[c*DataW +: DataW] = mem_q[drain_cnt][c];
            end
        end
    end

    // A byte lane is live when the column it belongs to lies inside the leftover width
    always_comb begin
        z_strb_o = '0;
        for (int b = 0; b < StrbW; b++) begin
            z_strb_o[b] = z_valid_o && (ColW'((b * 8) / DataW) < cols_q);
        end
    end

endmodule

// File: tb/tb_redmule_zbuf_seq.sv
// Bench for redmule_zbuf_seq: leftover vector table, directed corner sequences and a random run,
// all compared each cycle against a tile-level reference model.
module tb_redmule_zbuf_seq;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int DW = 16;
    localparam int RW = 4;
    localparam int CW = 5;
    localparam int SW = D * DW / 8;
    localparam int ZW = D * DW;

    logic          clk = 1'b0, rst_n = 1'b0, clear = 1'b0, clk_en = 1'b0, fill = 1'b0;
    logic          drain_en = 1'b0, z_rdy = 1'b0;
    logic [W*DW-1:0] z_in = '0;
    logic [RW-1:0] z_rows = '0;
    logic [CW-1:0] z_cols = '0;
    logic [ZW-1:0] z_dat;
    logic [SW-1:0] z_strb;
    logic          z_vld, full, empty;

    redmule_zbuf_seq #(.Height(4), .Width(W), .NumPipeRegs(3), .DataW(DW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .clk_en_i(clk_en), .fill_i(fill),
        .z_i(z_in), .z_rows_i(z_rows), .z_cols_i(z_cols), .drain_en_i(drain_en),
        .z_o(z_dat), .z_strb_o(z_strb), .z_valid_o(z_vld), .z_ready_i(z_rdy),
        .full_o(full), .empty_o(empty)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Tile-level reference model
    logic [DW-1:0] mtile [W][D];
    int  mfills, mrows, mcols, mrow, mdropped = 0;
    bit  mfull, mdrain, mempty;

    int  beat_cnt, empty_cnt, dut_dropped = 0;
    logic [SW-1:0] last_strb;
    bit  stall_prev = 0;
    logic [ZW-1:0] prev_z;

    typedef struct {
        logic [RW-1:0] rows;
        logic [CW-1:0] cols;
        int            beats;
        logic [SW-1:0] strb;
    } vec_t;
    vec_t vt [8];

    task automatic chk(input string nm, input logic [ZW-1:0] act, input logic [ZW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mfills = 0; mrows = 0; mcols = 0; mrow = 0;
        mfull = 0; mdrain = 0; mempty = 0;
    endtask

    task automatic model_step(input bit clr, input bit ce, input bit fl, input logic [W*DW-1:0] zz,
                              input int zr, input int zc, input bit de, input bit rd);
        mempty = 0;
        if (clr) begin
            model_reset();
        end else if (mdrain) begin
            if (fl && ce) mdropped++;
            if (rd) begin
                if (mrow == mrows - 1) begin
                    mdrain = 0;
                    mempty = 1;
                end else begin
                    mrow++;
                end
            end
        end else if (mfull) begin
            if (fl && ce) mdropped++;
            if (de) begin
                mfull = 0; mdrain = 1; mrow = 0;
            end
        end else if (fl && ce) begin
            if (mfills == 0) begin
                mrows = (zr == 0 || zr > W) ? W : zr;
                mcols = (zc == 0 || zc > D) ? D : zc;
            end
            for (int r = 0; r < W; r++) mtile[r][mfills] = zz[r*DW +: DW];
            mfills++;
            if (mfills == D) begin
                mfull = 1; mfills = 0;
            end
        end
    endtask

    task automatic check_outputs();
        logic [ZW-1:0] ez;
        logic [SW-1:0] es;
        ez = '0; es = '0;
        if (mdrain) begin
            for (int c = 0; c < D; c++) ez[c*DW +: DW] = mtile[mrow][c];
            for (int b = 0; b < SW; b++) es[b] = ((b * 8) / DW) < mcols;
        end
        chk("z_valid", ZW'(z_vld), ZW'(mdrain));
        chk("full", ZW'(full), ZW'(mfull));
        chk("empty", ZW'(empty), ZW'(mempty));
        chk("z_data", z_dat, ez);
        chk("z_strb", ZW'(z_strb), ZW'(es));
    endtask

    // Sample at the falling edge, then drive inputs for the next rising edge
    task automatic step(input bit clr, input bit ce, input bit fl, input logic [W*DW-1:0] zz,
                        input logic [RW-1:0] zr, input logic [CW-1:0] zc, input bit de, input bit rd);
        check_outputs();
        if (stall_prev) begin
            chk("stall_valid", ZW'(z_vld), ZW'(1));
            chk("stall_data", z_dat, prev_z);
        end
        if (z_vld && rd) begin
            beat_cnt++;
            last_strb = z_strb;
        end
        if (empty) empty_cnt++;
        if (fl && ce && !clr && (full || z_vld)) dut_dropped++;
        stall_prev = z_vld && !rd && !clr;
        prev_z = z_dat;
        clear = clr; clk_en = ce; fill = fl; z_in = zz; z_rows = zr; z_cols = zc;
        drain_en = de; z_rdy = rd;
        model_step(clr, ce, fl, zz, int'(zr), int'(zc), de, rd);
        @(negedge clk);
    endtask

    function automatic logic [W*DW-1:0] randz();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic fill_tile(input bit pattern, input logic [RW-1:0] zr, input logic [CW-1:0] zc);
        logic [W*DW-1:0] zz;
        for (int c = 0; c < D; c++) begin
            zz = randz();
            if (pattern) for (int r = 0; r < W; r++) zz[r*DW +: DW] = DW'(r * 16 + c);
            step(0, 1, 1, zz, zr, zc, 0, 0);
        end
        chk("full_after_last_fill", ZW'(full), ZW'(1));
    endtask

    task automatic drain_run(input int mode, input bit fill_during);
        bit rd;
        beat_cnt = 0; empty_cnt = 0; last_strb = '0;
        step(0, 1, fill_during && full, randz(), 0, 0, 1, 0);
        for (int i = 0; i < 100 && empty_cnt == 0; i++) begin
            case (mode)
                0:       rd = 1'b1;
                1:       rd = (i % 4 == 0) || (i % 4 == 3);
                default: rd = 1'($urandom_range(0, 1));
            endcase
            step(0, 1, fill_during && z_vld, randz(), 0, 0, i < 3, rd);
        end
        chk("drain_done", ZW'(empty_cnt > 0), ZW'(1));
        step(0, 1, 0, '0, 0, 0, 0, 0);
    endtask

    task automatic async_reset();
        clear = 0; fill = 0; drain_en = 0; z_rdy = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", ZW'(z_vld), ZW'(0));
        chk("arst_full", ZW'(full), ZW'(0));
        chk("arst_empty", ZW'(empty), ZW'(0));
        chk("arst_data", z_dat, '0);
        chk("arst_strb", ZW'(z_strb), ZW'(0));
        model_reset();
        stall_prev = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vt[0] = '{4'd0,  5'd0,  8, 32'hFFFF_FFFF};
        vt[1] = '{4'd3,  5'd5,  3, 32'h0000_03FF};
        vt[2] = '{4'd9,  5'd17, 8, 32'hFFFF_FFFF};
        vt[3] = '{4'd1,  5'd1,  1, 32'h0000_0003};
        vt[4] = '{4'd8,  5'd16, 8, 32'hFFFF_FFFF};
        vt[5] = '{4'd15, 5'd31, 8, 32'hFFFF_FFFF};
        vt[6] = '{4'd7,  5'd0,  7, 32'hFFFF_FFFF};
        vt[7] = '{4'd0,  5'd12, 8, 32'h00FF_FFFF};

        #1;
        chk("rst_valid", ZW'(z_vld), ZW'(0));
        chk("rst_full", ZW'(full), ZW'(0));
        chk("rst_empty", ZW'(empty), ZW'(0));
        chk("rst_data", z_dat, '0);
        chk("rst_strb", ZW'(z_strb), ZW'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Full default tile with the r*16+c pattern
        fill_tile(1, 0, 0);
        drain_run(0, 0);
        chk("t1_beats", ZW'(beat_cnt), ZW'(8));
        chk("t1_empty_pulses", ZW'(empty_cnt), ZW'(1));
        chk("t1_strb", ZW'(last_strb), ZW'(32'hFFFF_FFFF));

        // Leftover table
        for (int i = 0; i < 8; i++) begin
            fill_tile(0, vt[i].rows, vt[i].cols);
            drain_run(0, 0);
            chk($sformatf("vec%0d_beats", i), ZW'(beat_cnt), ZW'(vt[i].beats));
            chk($sformatf("vec%0d_empty", i), ZW'(empty_cnt), ZW'(1));
            chk($sformatf("vec%0d_strb", i), ZW'(last_strb), ZW'(vt[i].strb));
        end

        // Backpressure with drain_en dropped mid-drain
        fill_tile(1, 0, 0);
        drain_run(1, 0);
        chk("bp_beats", ZW'(beat_cnt), ZW'(8));
        chk("bp_empty", ZW'(empty_cnt), ZW'(1));

        // Gated fill then illegal fills in FULL and DRAINING
        for (int i = 0; i < 17; i++) begin
            step(0, i != 4, 1, randz(), 4'd2, 5'd6, 0, 0);
            if (i == 15) chk("gated_not_full", ZW'(full), ZW'(0));
        end
        chk("gated_full", ZW'(full), ZW'(1));
        for (int i = 0; i < 3; i++) step(0, 1, 1, randz(), 0, 0, 0, 0);
        drain_run(2, 1);
        chk("gated_beats", ZW'(beat_cnt), ZW'(2));

        // Soft clear in the middle of a drain
        fill_tile(0, 0, 0);
        beat_cnt = 0; empty_cnt = 0;
        step(0, 1, 0, '0, 0, 0, 1, 0);
        step(0, 1, 0, '0, 0, 0, 0, 1);
        step(0, 1, 0, '0, 0, 0, 0, 1);
        step(1, 1, 0, '0, 0, 0, 0, 1);
        chk("clr_valid", ZW'(z_vld), ZW'(0));
        step(0, 1, 0, '0, 0, 0, 0, 1);
        step(0, 1, 0, '0, 0, 0, 0, 1);
        chk("clr_no_empty", ZW'(empty_cnt), ZW'(0));
        fill_tile(1, 0, 0);
        drain_run(0, 0);
        chk("clr_next_beats", ZW'(beat_cnt), ZW'(8));

        // Async reset mid-fill, then leftovers re-latched
        for (int i = 0; i < 7; i++) step(0, 1, 1, randz(), 4'd2, 5'd3, 0, 0);
        async_reset();
        fill_tile(0, 4'd5, 5'd9);
        drain_run(0, 0);
        chk("arst_beats", ZW'(beat_cnt), ZW'(5));
        chk("arst_strb_new", ZW'(last_strb), ZW'(32'h0003_FFFF));

        // Async reset while draining
        fill_tile(0, 0, 0);
        step(0, 1, 0, '0, 0, 0, 1, 0);
        step(0, 1, 0, '0, 0, 0, 0, 0);
        async_reset();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 59) == 0, $urandom_range(0, 4) != 0, $urandom_range(0, 9) < 6,
                 randz(), RW'($urandom_range(0, 15)), CW'($urandom_range(0, 31)),
                 $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 6);
        end
        chk("dropped_fills", ZW'(dut_dropped), ZW'(mdropped));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
